// File: rtl/f64_clk_rst_seq_pkg.sv
// Shared definitions for the f64 clock-enable / reset sequencer: state encodings
// and the default channel layout.
package f64_clk_rst_seq_pkg;

  localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [1:0] ST_STRETCH   = 2'd1;
  localparam logic [1:0] ST_RELEASE   = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  // Default layout: ch0 /2, ch1 /4, ch2 /8, one DEF_DIV_W-bit field per channel.
  localparam int          DEF_NUM_CH   = 3;
  localparam int          DEF_DIV_W    = 4;
  localparam logic [11:0] DEF_DIV_LIST = 12'h842;

endpackage

// File: rtl/f64_sync2.sv
// Two-flop synchroniser with a selectable asynchronous reset value.
module f64_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/f64_clk_rst_seq.sv
// Clock-enable generator and staggered reset sequencer: waits for a stable PLL lock,
// releases channel resets one by one, then runs divided enable pulses per channel.
module f64_clk_rst_seq
  import f64_clk_rst_seq_pkg::*;
#(
  parameter int                       NUM_CH   = DEF_NUM_CH,
  parameter int                       DIV_W    = DEF_DIV_W,
  parameter logic [NUM_CH*DIV_W-1:0]  DIV_LIST = DEF_DIV_LIST,
  parameter int                       STRETCH  = 8,
  parameter int                       STAGGER  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic              soft_rst_req,
  output logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] ch_rst,
  output logic              sys_ready,
  output logic [1:0]        dbg_state
);

  localparam int SC_W = $clog2(STRETCH + 1);
  localparam int GC_W = $clog2(STAGGER + 1);
  localparam logic [SC_W-1:0] STRETCH_LAST = SC_W'(STRETCH - 1);
  localparam logic [SC_W-1:0] STRETCH_SAT  = SC_W'(STRETCH);
  localparam logic [GC_W-1:0] STAGGER_V    = GC_W'(STAGGER);
  localparam logic [3:0]      LAST_IDX     = 4'(NUM_CH - 1);

  logic rst_int;
  logic lock_s;

  // rst asserts asynchronously but releases two edges later, clean to clk.
  f64_sync2 #(.RST_VAL(1'b1)) u_rst_sync (
    .clk (clk), .rst (rst), .d (1'b0), .q (rst_int)
  );

  f64_sync2 #(.RST_VAL(1'b0)) u_lock_sync (
    .clk (clk), .rst (rst), .d (pll_locked), .q (lock_s)
  );

  logic [1:0]        state, state_n;
  logic [SC_W-1:0]   stretch_cnt, stretch_n, stretch_inc;
  logic [GC_W-1:0]   stag_cnt, stag_n, stag_inc;
  logic [3:0]        rel_idx, rel_n, rel_inc;
  logic [NUM_CH-1:0] ch_rst_n;
  logic              ready_n;

  assign stretch_inc = (stretch_cnt == STRETCH_SAT) ? stretch_cnt : stretch_cnt + SC_W'(1);
  assign stag_inc    = (stag_cnt == STAGGER_V) ? stag_cnt : stag_cnt + GC_W'(1);
  assign rel_inc     = rel_idx + 4'd1;
  assign dbg_state   = state;

  always_comb begin
    state_n   = state;
    stretch_n = stretch_cnt;
    stag_n    = stag_cnt;
    rel_n     = rel_idx;
    ch_rst_n  = ch_rst;
    ready_n   = sys_ready;
    case (state)
      ST_WAIT_LOCK: begin
        ch_rst_n  = '1;
        ready_n   = 1'b0;
        stretch_n = '0;
        stag_n    = '0;
        rel_n     = '0;
        if (lock_s) state_n = ST_STRETCH;
      end
      ST_STRETCH: begin
        if (!lock_s) begin
          state_n   = ST_WAIT_LOCK;
          stretch_n = '0;
        end else if (stretch_inc >= STRETCH_LAST) begin
          state_n     = ST_RELEASE;
          stretch_n   = '0;
          stag_n      = '0;
          rel_n       = '0;
          ch_rst_n[0] = 1'b0;
          if (LAST_IDX == 4'd0) begin
            state_n = ST_RUN;
            ready_n = 1'b1;
          end
        end else begin
          stretch_n = stretch_inc;
        end
      end
      default: begin
        // RELEASE and RUN share the abort paths; lock loss wins over a soft request.
        if (!lock_s) begin
          state_n   = ST_WAIT_LOCK;
          ch_rst_n  = '1;
          ready_n   = 1'b0;
          stretch_n = '0;
          stag_n    = '0;
          rel_n     = '0;
        end else if (soft_rst_req) begin
          state_n   = ST_STRETCH;
          ch_rst_n  = '1;
          ready_n   = 1'b0;
          stretch_n = '0;
          stag_n    = '0;
          rel_n     = '0;
        end else if (state == ST_RUN) begin
          ch_rst_n = '0;
          ready_n  = 1'b1;
        end else if (stag_inc >= STAGGER_V) begin
          stag_n = '0;
          rel_n  = rel_inc;
          for (int i = 1; i < NUM_CH; i++) begin
            if (4'(i) == rel_inc) ch_rst_n[i] = 1'b0;
          end
          if (rel_inc >= LAST_IDX) begin
            state_n = ST_RUN;
            ready_n = 1'b1;
          end
        end else begin
          stag_n = stag_inc;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state       <= ST_WAIT_LOCK;
      stretch_cnt <= '0;
      stag_cnt    <= '0;
      rel_idx     <= '0;
      ch_rst      <= '1;
      sys_ready   <= 1'b0;
    end else begin
      state       <= state_n;
      stretch_cnt <= stretch_n;
      stag_cnt    <= stag_n;
      rel_idx     <= rel_n;
      ch_rst      <= ch_rst_n;
      sys_ready   <= ready_n;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam logic [DIV_W-1:0] DIV_RAW = DIV_LIST[g*DIV_W +: DIV_W];
    // A zero ratio behaves as divide-by-one: terminal count 0, enable every cycle.
    localparam logic [DIV_W-1:0] DIV_TOP = (DIV_RAW == '0) ? '0 : DIV_RAW - DIV_W'(1);

    logic [DIV_W-1:0] div_cnt;
    logic             en_q;

    always_ff @(posedge clk or posedge rst_int) begin
      if (rst_int) begin
        div_cnt <= '0;
        en_q    <= 1'b0;
      end else if (ch_rst[g] || ch_rst_n[g]) begin
        div_cnt <= '0;
        en_q    <= 1'b0;
      end else begin
        en_q    <= (div_cnt == DIV_TOP);
        div_cnt <= (div_cnt == DIV_TOP) ? '0 : div_cnt + DIV_W'(1);
      end
    end

    assign ch_en[g] = en_q;
  end

endmodule
